// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, flags illegal instructions and counts retired instructions.
module multicycle_control_unit #(
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             opcode_i,
   input  logic [5:0]             funct_i,
   input  logic                   zero_i,
   output logic                   enable_PC,
   output logic                   Selector_Addr,
   output logic                   enable_MemSys,
   output logic                   enable_RegIns,
   output logic                   enable_RF,
   output logic                   Selector_RF_WR,
   output logic                   Selector_RF_WD,
   output logic                   Selector_ALU_Src_A,
   output logic [1:0]             Selector_ALU_Src_B,
   output logic [2:0]             Selector_ALU_Op,
   output logic                   Selector_PC_Source,
   output logic                   illegal_o,
   output logic [3:0]             state_o,
   output logic [COUNT_WIDTH-1:0] instr_count_o
);

   typedef enum logic [3:0] {
      INIT      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      EXECUTE   = 4'd7,
      ALU_WB    = 4'd8,
      IMM_EXEC  = 4'd9,
      IMM_WB    = 4'd10,
      BRANCH    = 4'd11,
      ILLEGAL   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t state_q, state_d;
   logic [2:0] funct_op;
   logic       funct_ok;
   logic       retire;

   always_comb begin
      funct_op = ALU_ADD;
      funct_ok = 1'b1;
      case (funct_i)
         6'h20:   funct_op = ALU_ADD;
         6'h22:   funct_op = ALU_SUB;
         6'h24:   funct_op = ALU_AND;
         6'h25:   funct_op = ALU_OR;
         6'h27:   funct_op = ALU_NOR;
         6'h2A:   funct_op = ALU_SLT;
         default: funct_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= INIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d            = INIT;
      enable_PC          = 1'b0;
      Selector_Addr      = 1'b0;
      enable_MemSys      = 1'b0;
      enable_RegIns      = 1'b0;
      enable_RF          = 1'b0;
      Selector_RF_WR     = 1'b0;
      Selector_RF_WD     = 1'b0;
      Selector_ALU_Src_A = 1'b0;
      Selector_ALU_Src_B = 2'b00;
      Selector_ALU_Op    = ALU_ADD;
      Selector_PC_Source = 1'b0;
      illegal_o          = 1'b0;
      retire             = 1'b0;
      case (state_q)
         INIT: state_d = FETCH;
         FETCH: begin
            enable_RegIns      = 1'b1;
            Selector_ALU_Src_B = 2'b01;
            enable_PC          = 1'b1;
            state_d            = DECODE;
         end
         DECODE: begin
            Selector_ALU_Src_B = 2'b11;
            case (opcode_i)
               OP_LW, OP_SW:    state_d = MEM_ADDR;
               OP_RTYPE:        state_d = funct_ok ? EXECUTE : ILLEGAL;
               OP_ADDI, OP_ORI: state_d = IMM_EXEC;
               OP_BEQ, OP_BNE:  state_d = BRANCH;
               default:         state_d = ILLEGAL;
            endcase
         end
         MEM_ADDR: begin
            Selector_ALU_Src_A = 1'b1;
            Selector_ALU_Src_B = 2'b10;
            state_d            = (opcode_i == OP_SW) ? MEM_WRITE : MEM_READ;
         end
         // Address mux takes the live ALU result, so keep the address computation running.
         MEM_READ: begin
            Selector_Addr      = 1'b1;
            Selector_ALU_Src_A = 1'b1;
            Selector_ALU_Src_B = 2'b10;
            state_d            = MEM_WB;
         end
         MEM_WB: begin
            Selector_RF_WD = 1'b1;
            enable_RF      = 1'b1;
            retire         = 1'b1;
            state_d        = FETCH;
         end
         MEM_WRITE: begin
            Selector_Addr      = 1'b1;
            Selector_ALU_Src_A = 1'b1;
            Selector_ALU_Src_B = 2'b10;
            enable_MemSys      = 1'b1;
            retire             = 1'b1;
            state_d            = FETCH;
         end
         EXECUTE: begin
            Selector_ALU_Src_A = 1'b1;
            Selector_ALU_Op    = funct_op;
            state_d            = ALU_WB;
         end
         ALU_WB: begin
            Selector_RF_WR  = 1'b1;
            enable_RF       = 1'b1;
            Selector_ALU_Op = funct_op;
            retire          = 1'b1;
            state_d         = FETCH;
         end
         IMM_EXEC: begin
            Selector_ALU_Src_A = 1'b1;
            Selector_ALU_Src_B = 2'b10;
            Selector_ALU_Op    = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
            state_d            = IMM_WB;
         end
         IMM_WB: begin
            enable_RF = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            Selector_ALU_Src_A = 1'b1;
            Selector_ALU_Op    = ALU_SUB;
            Selector_PC_Source = 1'b1;
            enable_PC          = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
            retire             = 1'b1;
            state_d            = FETCH;
         end
         ILLEGAL: begin
            illegal_o = 1'b1;
            state_d   = FETCH;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       instr_count_o <= '0;
      else if (retire) instr_count_o <= instr_count_o + COUNT_WIDTH'(1);
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit: walks a fixed instruction
// sequence and compares state, packed control outputs and the retired count each cycle.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode_i, funct_i;
   logic        zero_i;
   logic        enable_PC, Selector_Addr, enable_MemSys, enable_RegIns, enable_RF;
   logic        Selector_RF_WR, Selector_RF_WD, Selector_ALU_Src_A, Selector_PC_Source;
   logic [1:0]  Selector_ALU_Src_B;
   logic [2:0]  Selector_ALU_Op;
   logic        illegal_o;
   logic [3:0]  state_o;
   logic [31:0] instr_count_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   multicycle_control_unit #(.COUNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct_i(funct_i), .zero_i(zero_i),
      .enable_PC(enable_PC), .Selector_Addr(Selector_Addr), .enable_MemSys(enable_MemSys),
      .enable_RegIns(enable_RegIns), .enable_RF(enable_RF), .Selector_RF_WR(Selector_RF_WR),
      .Selector_RF_WD(Selector_RF_WD), .Selector_ALU_Src_A(Selector_ALU_Src_A),
      .Selector_ALU_Src_B(Selector_ALU_Src_B), .Selector_ALU_Op(Selector_ALU_Op),
      .Selector_PC_Source(Selector_PC_Source), .illegal_o(illegal_o), .state_o(state_o),
      .instr_count_o(instr_count_o)
   );

   always #5 clk = ~clk;

   // {pc, addr, mem, ri, rf, wr, wd, srcA, srcB[1:0], op[2:0], pcsrc, illegal}
   logic [14:0] ctrl;
   assign ctrl = {enable_PC, Selector_Addr, enable_MemSys, enable_RegIns, enable_RF,
                  Selector_RF_WR, Selector_RF_WD, Selector_ALU_Src_A, Selector_ALU_Src_B,
                  Selector_ALU_Op, Selector_PC_Source, illegal_o};

   localparam logic [14:0] C_NONE   = 15'b0_0_0_0_0_0_0_0_00_000_0_0;
   localparam logic [14:0] C_FETCH  = 15'b1_0_0_1_0_0_0_0_01_000_0_0;
   localparam logic [14:0] C_DEC    = 15'b0_0_0_0_0_0_0_0_11_000_0_0;
   localparam logic [14:0] C_MADDR  = 15'b0_0_0_0_0_0_0_1_10_000_0_0;
   localparam logic [14:0] C_MREAD  = 15'b0_1_0_0_0_0_0_1_10_000_0_0;
   localparam logic [14:0] C_MWB    = 15'b0_0_0_0_1_0_1_0_00_000_0_0;
   localparam logic [14:0] C_MWRITE = 15'b0_1_1_0_0_0_0_1_10_000_0_0;
   localparam logic [14:0] C_EX_SLT = 15'b0_0_0_0_0_0_0_1_00_101_0_0;
   localparam logic [14:0] C_WB_SLT = 15'b0_0_0_0_1_1_0_0_00_101_0_0;
   localparam logic [14:0] C_EX_NOR = 15'b0_0_0_0_0_0_0_1_00_100_0_0;
   localparam logic [14:0] C_WB_NOR = 15'b0_0_0_0_1_1_0_0_00_100_0_0;
   localparam logic [14:0] C_BR_TK  = 15'b1_0_0_0_0_0_0_1_00_001_1_0;
   localparam logic [14:0] C_BR_NT  = 15'b0_0_0_0_0_0_0_1_00_001_1_0;
   localparam logic [14:0] C_IM_ADD = 15'b0_0_0_0_0_0_0_1_10_000_0_0;
   localparam logic [14:0] C_IM_OR  = 15'b0_0_0_0_0_0_0_1_10_011_0_0;
   localparam logic [14:0] C_IMM_WB = 15'b0_0_0_0_1_0_0_0_00_000_0_0;
   localparam logic [14:0] C_ILL    = 15'b0_0_0_0_0_0_0_0_00_000_0_1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [3:0] st, input logic [14:0] c);
      @(negedge clk);
      check({tag, "_state"}, 32'(state_o), 32'(st));
      check({tag, "_ctrl"}, 32'(ctrl), 32'(c));
   endtask

   initial begin
      reset = 1'b1; opcode_i = 6'h23; funct_i = 6'h00; zero_i = 1'b0;
      cyc("rst", 4'd0, C_NONE);
      check("rst_count", instr_count_o, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      cyc("init", 4'd0, C_NONE);

      // lw: 1,2,3,4,5
      cyc("lw_f", 4'd1, C_FETCH);
      check("lw_count0", instr_count_o, 32'd0);
      cyc("lw_d", 4'd2, C_DEC);
      cyc("lw_ma", 4'd3, C_MADDR);
      cyc("lw_mr", 4'd4, C_MREAD);
      cyc("lw_wb", 4'd5, C_MWB);
      check("lw_count_wb", instr_count_o, 32'd0);

      cyc("slt_f", 4'd1, C_FETCH);
      check("count1", instr_count_o, 32'd1);
      opcode_i = 6'h00; funct_i = 6'h2A;
      cyc("slt_d", 4'd2, C_DEC);
      cyc("slt_ex", 4'd7, C_EX_SLT);
      cyc("slt_wb", 4'd8, C_WB_SLT);

      cyc("nor_f", 4'd1, C_FETCH);
      check("count2", instr_count_o, 32'd2);
      funct_i = 6'h27;
      cyc("nor_d", 4'd2, C_DEC);
      cyc("nor_ex", 4'd7, C_EX_NOR);
      cyc("nor_wb", 4'd8, C_WB_NOR);

      cyc("beq1_f", 4'd1, C_FETCH);
      check("count3", instr_count_o, 32'd3);
      opcode_i = 6'h04; zero_i = 1'b1;
      cyc("beq1_d", 4'd2, C_DEC);
      cyc("beq1_br", 4'd11, C_BR_TK);

      cyc("beq0_f", 4'd1, C_FETCH);
      zero_i = 1'b0;
      cyc("beq0_d", 4'd2, C_DEC);
      cyc("beq0_br", 4'd11, C_BR_NT);

      cyc("bne0_f", 4'd1, C_FETCH);
      check("count5", instr_count_o, 32'd5);
      opcode_i = 6'h05;
      cyc("bne0_d", 4'd2, C_DEC);
      cyc("bne0_br", 4'd11, C_BR_TK);

      cyc("addi_f", 4'd1, C_FETCH);
      opcode_i = 6'h08;
      cyc("addi_d", 4'd2, C_DEC);
      cyc("addi_ex", 4'd9, C_IM_ADD);
      cyc("addi_wb", 4'd10, C_IMM_WB);

      cyc("ori_f", 4'd1, C_FETCH);
      check("count7", instr_count_o, 32'd7);
      opcode_i = 6'h0D;
      cyc("ori_d", 4'd2, C_DEC);
      cyc("ori_ex", 4'd9, C_IM_OR);
      cyc("ori_wb", 4'd10, C_IMM_WB);

      cyc("sw_f", 4'd1, C_FETCH);
      opcode_i = 6'h2B;
      cyc("sw_d", 4'd2, C_DEC);
      cyc("sw_ma", 4'd3, C_MADDR);
      cyc("sw_mw", 4'd6, C_MWRITE);

      cyc("ill_f", 4'd1, C_FETCH);
      check("count9", instr_count_o, 32'd9);
      opcode_i = 6'h3F;
      cyc("ill_d", 4'd2, C_DEC);
      cyc("ill_st", 4'd12, C_ILL);

      // R-type with an undefined funct is illegal too; count must not move.
      cyc("illf_f", 4'd1, C_FETCH);
      check("count9_ill", instr_count_o, 32'd9);
      opcode_i = 6'h00; funct_i = 6'h21;
      cyc("illf_d", 4'd2, C_DEC);
      cyc("illf_st", 4'd12, C_ILL);

      cyc("sw2_f", 4'd1, C_FETCH);
      check("count9_illf", instr_count_o, 32'd9);
      opcode_i = 6'h2B;
      cyc("sw2_d", 4'd2, C_DEC);
      cyc("sw2_ma", 4'd3, C_MADDR);
      cyc("sw2_mw", 4'd6, C_MWRITE);

      // Reset in the middle of MEM_WRITE, away from a clock edge.
      #1 reset = 1'b1;
      #1;
      check("arst_mem", 32'(enable_MemSys), 32'd0);
      check("arst_state", 32'(state_o), 32'd0);
      check("arst_count", instr_count_o, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      cyc("rinit", 4'd0, C_NONE);
      cyc("rfetch", 4'd1, C_FETCH);
      check("rcount", instr_count_o, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style control FSM that drives every control input of the multicycle MIPS datapath, one instruction at a time. It decodes the opcode and funct fields of the instruction register and sequences the fetch, decode, execute, memory and writeback steps. It also reports an illegal-instruction flag, the current state and a retired-instruction count for debug.

Parameters:
COUNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
opcode_i  in  6  instruction register bits [31:26]
funct_i  in  6  instruction register bits [5:0]
zero_i  in  1  ALU result == 0, combinational from the datapath in the same cycle
enable_PC  out  1  PC write enable
Selector_Addr  out  1  memory address source: 0 = PC, 1 = ALU result
enable_MemSys  out  1  memory write enable
enable_RegIns  out  1  instruction register load
enable_RF  out  1  register file write
Selector_RF_WR  out  1  write register: 0 = rt, 1 = rd
Selector_RF_WD  out  1  write data: 0 = ALUOut register, 1 = data register
Selector_ALU_Src_A  out  1  0 = PC, 1 = register A
Selector_ALU_Src_B  out  2  00 = register B, 01 = constant 4, 10 = SignExt, 11 = SignExt<<2
Selector_ALU_Op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOR, 101 SLT
Selector_PC_Source  out  1  0 = ALU result, 1 = ALUOut register
illegal_o  out  1  high during the ILLEGAL state
state_o  out  4  current state encoding
instr_count_o  out  COUNT_WIDTH  retired instructions

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-high reset forces the state to INIT and instr_count_o to 0.
- Output decode: outputs are a combinational decode of the registered state. The one exception is enable_PC in BRANCH, which also depends on zero_i. Any signal not listed for a state is 0.
- Reset values: INIT drives all outputs to 0 (state_o = 0). INIT always goes to FETCH on the next cycle.
- Decoded instructions:
  - R-type opcode 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
  - addi 0x08, ori 0x0D (uses the sign-extended immediate), lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - Any other opcode, or any other funct when opcode = 0x00, is illegal.
- States (state_o encoding in brackets):
  - FETCH[1]: Addr=0, enable_RegIns=1, SrcA=0, SrcB=01, ADD, PCSrc=0, enable_PC=1. Next state DECODE.
  - DECODE[2]: SrcA=0, SrcB=11, ADD, which latches the branch target into ALUOut. Next state:
    - lw or sw → MEM_ADDR
    - R-type → EXECUTE
    - addi or ori → IMM_EXEC
    - beq or bne → BRANCH
    - otherwise → ILLEGAL
  - MEM_ADDR[3]: SrcA=1, SrcB=10, ADD. Next state MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ[4]: Addr=1, SrcA=1, SrcB=10, ADD. The ALU must keep producing the address because the address mux takes the live ALU result. Next state MEM_WB.
  - MEM_WB[5]: RF_WR=0, RF_WD=1, enable_RF=1. Next state FETCH.
  - MEM_WRITE[6]: Addr=1, SrcA=1, SrcB=10, ADD, enable_MemSys=1. Next state FETCH.
  - EXECUTE[7]: SrcA=1, SrcB=00, ALU op mapped from funct. Next state ALU_WB.
  - ALU_WB[8]: RF_WR=1, RF_WD=0, enable_RF=1, with the ALU op held from EXECUTE. Next state FETCH.
  - IMM_EXEC[9]: SrcA=1, SrcB=10, ADD for addi, OR for ori. Next state IMM_WB.
  - IMM_WB[10]: RF_WR=0, RF_WD=0, enable_RF=1. Next state FETCH.
  - BRANCH[11]: SrcA=1, SrcB=00, SUB, PCSrc=1. enable_PC = zero_i for beq, ~zero_i for bne. Next state FETCH.
  - ILLEGAL[12]: illegal_o=1, all enables 0, so no architectural state changes. Next state FETCH.
- Instruction register stability: enable_RegIns is asserted only in FETCH, so opcode_i and funct_i are stable from DECODE through writeback.
- Latency from FETCH to the next FETCH:
  - lw 5 cycles
  - sw, R-type, addi, ori 4 cycles
  - beq, bne, illegal 3 cycles
- instr_count_o:
  - Increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, IMM_WB or BRANCH.
  - Does not increment from INIT or ILLEGAL.
  - Wraps modulo 2^COUNT_WIDTH.
- Reset mid-instruction: reset asserted mid-instruction aborts it immediately with no enable glitch past the reset edge. After release: INIT for 1 cycle, then FETCH.
- Unused state encodings go to INIT on the next clock.

Test Plan:
- Reset asserted at an arbitrary time, then released → state_o = 0 and all outputs 0 for 1 cycle, then FETCH with enable_PC=1, enable_RegIns=1, SrcB=01; instr_count_o = 0.
- lw (opcode 0x23) → states 1,2,3,4,5,1; Addr=1 only in MEM_READ; enable_RF=1 with RF_WD=1 and RF_WR=0 in MEM_WB; instr_count_o 0→1.
- R-type with funct 0x2A then funct 0x27 → Selector_ALU_Op = 101 then 100 in EXECUTE/ALU_WB; RF_WR=1; each instruction takes 4 cycles.
- beq with zero_i=1, then beq with zero_i=0, then bne with zero_i=0 → enable_PC in BRANCH = 1, 0, 1; PCSrc=1; SrcB=00; ALU op SUB.
- sw (0x2B) followed by an illegal opcode 0x3F → enable_MemSys=1 for exactly one cycle; illegal_o=1 for one cycle; no enable_RF/enable_MemSys/enable_PC during ILLEGAL; count advances only for sw.
- Reset asserted during MEM_WRITE → enable_MemSys drops asynchronously; restart at INIT; count cleared to 0.
